// File: rtl/hash_digest_out.sv
// Digest output stage: captures the final 256-bit chaining value {li,ri} and
// streams it as eight 32-bit words over a valid/ready interface.
module hash_digest_out #(
    parameter int BYTE_SWAP = 0,
    parameter int CNT_W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] li,
    input  logic [127:0] ri,
    input  logic         clr,
    output logic [31:0]  do_data,
    output logic         do_valid,
    input  logic         do_ready,
    output logic         do_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = '1;

    state_t           r_state;
    logic [255:0]     r_hold;
    logic [CNT_W-1:0] r_cnt;

    logic             w_hs;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [255:0]     w_hold_shift;

    function automatic logic [31:0] fmt_word(input logic [31:0] w);
        if (BYTE_SWAP != 0)
            return {w[7:0], w[15:8], w[23:16], w[31:24]};
        else
            return w;
    endfunction

    assign w_hs         = do_valid & do_ready;
    assign w_cnt_nxt    = r_cnt + 1'b1;
    assign w_hold_shift = {r_hold[223:0], 32'h0};

    // Outputs are registered; the word following a handshake is taken from
    // the second word slot of the holding register, which shifts up in step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_cnt    <= '0;
            do_data  <= '0;
            do_valid <= 1'b0;
            do_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (clr) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_cnt    <= '0;
            do_data  <= '0;
            do_valid <= 1'b0;
            do_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_hold   <= {li, ri};
                        r_cnt    <= '0;
                        r_state  <= SEND;
                        do_valid <= 1'b1;
                        do_data  <= fmt_word(li[127:96]);
                        do_last  <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        r_hold <= w_hold_shift;
                        r_cnt  <= w_cnt_nxt;
                        if (r_cnt == LAST_IDX) begin
                            r_state  <= FIN;
                            do_valid <= 1'b0;
                            do_data  <= '0;
                            do_last  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            do_data <= fmt_word(r_hold[223:192]);
                            do_last <= (w_cnt_nxt == LAST_IDX);
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    do_valid <= 1'b0;
                    do_data  <= '0;
                    do_last  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_digest_out.sv
// Bench for hash_digest_out: directed digests, scoreboard queues per instance,
// and a negedge monitor that checks every handshake, stall and done pulse.
module tb_hash_digest_out;

    typedef struct {
        logic        is_done;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         start1 = 1'b0;
    logic [127:0] li = '0;
    logic [127:0] ri = '0;
    logic         clr = 1'b0;
    logic         do_ready = 1'b1;

    logic [31:0]  do_data, do_data1;
    logic         do_valid, do_valid1, do_last, do_last1;
    logic         busy, busy1, done, done1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [127:0] VA = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] VB = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] VC = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] VD = 128'h0F1E2D3C_4B5A6978_87965A4B_C3D2E1F0;
    localparam logic [127:0] VE = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] VF = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] VG = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] VH = 128'h0BADF00D_FEEDFACE_01010101_80808080;

    hash_digest_out #(.BYTE_SWAP(0), .CNT_W(3)) dut0 (
        .clk(clk), .rst(rst), .start(start), .li(li), .ri(ri), .clr(clr),
        .do_data(do_data), .do_valid(do_valid), .do_ready(do_ready),
        .do_last(do_last), .busy(busy), .done(done)
    );

    hash_digest_out #(.BYTE_SWAP(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .li(li), .ri(ri), .clr(clr),
        .do_data(do_data1), .do_valid(do_valid1), .do_ready(do_ready),
        .do_last(do_last1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_digest(input logic [127:0] l, input logic [127:0] r);
        logic [255:0] h;
        exp_t e;
        h = {l, r};
        for (int i = 0; i < 8; i++) begin
            e.is_done = 1'b0;
            e.data    = h[255-32*i -: 32];
            e.last    = (i == 7);
            q0.push_back(e);
        end
        e.is_done = 1'b1;
        e.data    = '0;
        e.last    = 1'b0;
        q0.push_back(e);
    endtask

    task automatic start0(input logic [127:0] l, input logic [127:0] r);
        li    = l;
        ri    = r;
        start = 1'b1;
        push_digest(l, r);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int c = 0; c < 100 && busy; c++) tick();
        if (busy) fail_now({nm, "_timeout"});
    endtask

    // Monitor for the pass-through instance.
    initial begin : mon0
        logic pv, pr, pl, phl, hs;
        logic [31:0] pd;
        exp_t e;
        pv = 0; pr = 0; pl = 0; phl = 0; pd = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 0;
                phl = 0;
            end else begin
                hs = do_valid && do_ready;
                if (pv && !pr) begin
                    chk("stall_valid", {31'b0, do_valid}, 32'd1);
                    chk("stall_data", do_data, pd);
                    chk("stall_last", {31'b0, do_last}, {31'b0, pl});
                end
                if (done || phl) chk("done_after_last", {31'b0, done}, {31'b0, phl});
                if (!do_valid) chk("data_zero_when_invalid", do_data, 32'd0);
                if (hs) begin
                    if (q0.size() == 0) fail_now("unexpected_word");
                    else begin
                        e = q0.pop_front();
                        chk("word_kind", {31'b0, e.is_done}, 32'd0);
                        chk("word_data", do_data, e.data);
                        chk("word_last", {31'b0, do_last}, {31'b0, e.last});
                    end
                end
                if (done) begin
                    if (q0.size() == 0) fail_now("unexpected_done");
                    else begin
                        e = q0.pop_front();
                        chk("done_kind", {31'b0, e.is_done}, 32'd1);
                    end
                end
                pv = do_valid; pr = do_ready; pd = do_data; pl = do_last;
                phl = hs && do_last;
                if (clr) begin
                    pv = 0;
                    phl = 0;
                end
            end
        end
    end

    // Monitor for the byte-swapping instance.
    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && do_valid1 && do_ready) begin
                if (q1.size() == 0) fail_now("swap_unexpected_word");
                else begin
                    e = q1.pop_front();
                    chk("swap_word", do_data1, e.data);
                    chk("swap_last", {31'b0, do_last1}, {31'b0, e.last});
                end
            end
        end
    end

    initial begin : drv
        logic [31:0] swp [8];
        exp_t e;
        swp = '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC,
                32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476};

        // Reset state
        tick(); tick();
        chk("rst_valid", {31'b0, do_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_last", {31'b0, do_last}, 32'd0);
        chk("rst_data", do_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Streaming with ready held high; li/ri changed without start
        li = VG; ri = VH;
        tick();
        chk("idle_no_capture", {31'b0, busy}, 32'd0);
        start0(VA, VB);
        chk("lat_first_valid", {31'b0, do_valid}, 32'd1);
        chk("lat_first_word", do_data, 32'h00112233);
        chk("lat_busy", {31'b0, busy}, 32'd1);
        li = VG; ri = VH;
        repeat (7) tick();
        chk("lat_last_word", do_data, 32'h76543210);
        chk("lat_last_flag", {31'b0, do_last}, 32'd1);
        tick();
        chk("lat_done", {31'b0, done}, 32'd1);
        chk("fin_valid", {31'b0, do_valid}, 32'd0);
        chk("fin_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_done", {31'b0, done}, 32'd0);

        // Backpressure on alternate cycles
        start0(VA, VB);
        for (int c = 0; c < 64 && busy; c++) begin
            do_ready = c[0];
            tick();
        end
        if (busy) fail_now("backpressure_timeout");
        do_ready = 1'b1;
        tick();

        // start while busy is ignored
        start0(VA, VB);
        tick();
        li = VC; ri = VD; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("busy_start");
        tick();

        // clr at word 3, then reset mid-SEND of a second digest
        start0(VC, VD);
        tick(); tick(); tick();
        chk("clr_at_word3", do_data, 32'h9ABCDEF0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        q0.delete();
        chk("clr_valid", {31'b0, do_valid}, 32'd0);
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_data", do_data, 32'd0);
        repeat (3) tick();
        start0(VE, VF);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_async_valid", {31'b0, do_valid}, 32'd0);
        chk("rst_async_busy", {31'b0, busy}, 32'd0);
        chk("rst_async_data", do_data, 32'd0);
        q0.delete();
        tick();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_done", {31'b0, done}, 32'd0);
        start0(VG, VH);
        chk("fresh_first", do_data, 32'hA5A5A5A5);
        wait_idle("fresh");
        tick();

        // Back-to-back: start in the IDLE cycle right after FIN
        start0(VA, VB);
        for (int c = 0; c < 20 && !done; c++) tick();
        if (!done) fail_now("b2b_done_timeout");
        tick();
        start0(VC, VD);
        chk("b2b_valid", {31'b0, do_valid}, 32'd1);
        chk("b2b_first", do_data, 32'hDEADBEEF);
        wait_idle("b2b");
        tick();

        // Byte-swapped instance
        for (int i = 0; i < 8; i++) begin
            e.is_done = 1'b0;
            e.data    = swp[i];
            e.last    = (i == 7);
            q1.push_back(e);
        end
        li = VA; ri = VB; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("swap_first_direct", do_data1, 32'h33221100);
        for (int c = 0; c < 20 && busy1; c++) tick();
        if (busy1) fail_now("swap_timeout");
        tick(); tick();

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
